// File: rtl/muldiv_pkg.sv
// Shared encodings for the Execute-stage multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MFHI  = 3'd4,
      MD_MFLO  = 3'd5,
      MD_MTHI  = 3'd6,
      MD_MTLO  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_e;

   // True for the multi-cycle arithmetic ops that occupy the FSM.
   function automatic logic is_muldiv(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module muldiv_absneg #(
   parameter int unsigned W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val_c
);

   assign o_val_c = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MFHI/MFLO/MTHI/MTLO support.
// Optional divide-by-zero flag output enabled by defining MULDIV_DIVZ_FLAG_EN.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] result_o
`ifdef MULDIV_DIVZ_FLAG_EN
   ,
   output logic             divz_o
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   md_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_p, r_q, r_m, r_hi, r_lo;
   logic               r_is_div, r_neg_q, r_neg_r, r_done;

   md_op_e             w_op;
   logic               w_md_start, w_signed, w_div_op, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo_fix, w_rem_fix, w_rem_nxt;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH:0]     w_add, w_shl;
   logic               w_ge;

   assign w_op       = md_op_e'(op_i);
   assign w_div_op   = (w_op == MD_DIV) || (w_op == MD_DIVU);
   assign w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
   assign w_a_neg    = w_signed && a_i[WIDTH-1];
   assign w_b_neg    = w_signed && b_i[WIDTH-1];
   assign w_md_start = start_i && is_muldiv(w_op) && (r_state == IDLE);

   muldiv_absneg #(.W(WIDTH))   u_abs_a    (.i_neg(w_a_neg), .i_val(a_i),        .o_val_c(w_a_mag));
   muldiv_absneg #(.W(WIDTH))   u_abs_b    (.i_neg(w_b_neg), .i_val(b_i),        .o_val_c(w_b_mag));
   muldiv_absneg #(.W(2*WIDTH)) u_fix_prod (.i_neg(r_neg_q), .i_val({r_p, r_q}), .o_val_c(w_prod_fix));
   muldiv_absneg #(.W(WIDTH))   u_fix_quo  (.i_neg(r_neg_q), .i_val(r_q),        .o_val_c(w_quo_fix));
   muldiv_absneg #(.W(WIDTH))   u_fix_rem  (.i_neg(r_neg_r), .i_val(r_p),        .o_val_c(w_rem_fix));

   // One shift-add step: r_p is the running high half, r_q the multiplier shifting out.
   assign w_add = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : '0);

   // One restoring-divide step: r_p is the partial remainder, r_q the dividend/quotient.
   assign w_shl     = {r_p, r_q[WIDTH-1]};
   assign w_ge      = (w_shl >= {1'b0, r_m});
   assign w_rem_nxt = w_ge ? (w_shl[WIDTH-1:0] - r_m) : w_shl[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_md_start) w_state_nxt = RUN;
         RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (flush_i) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_p      <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_md_start && !flush_i) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_p      <= '0;
            r_q      <= w_a_mag;
            r_m      <= w_b_mag;
            r_is_div <= w_div_op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
         end
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_is_div) begin
            r_p <= w_rem_nxt;
            r_q <= {r_q[WIDTH-2:0], w_ge};
         end else begin
            r_p <= w_add[WIDTH:1];
            r_q <= {w_add[0], r_q[WIDTH-1:1]};
         end
      end
   end

   // HI/LO: written by FIX completion or by MTHI/MTLO in IDLE; a flush blocks both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == FIX) && !flush_i;
         if ((r_state == FIX) && !flush_i) begin
            if (r_is_div) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end else begin
               {r_hi, r_lo} <= w_prod_fix;
            end
         end else if ((r_state == IDLE) && start_i && !flush_i) begin
            if (w_op == MD_MTHI) r_hi <= a_i;
            if (w_op == MD_MTLO) r_lo <= a_i;
         end
      end
   end

`ifdef MULDIV_DIVZ_FLAG_EN
   logic r_divz_pend, r_divz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divz_pend <= 1'b0;
         r_divz      <= 1'b0;
      end else begin
         if (w_md_start && !flush_i) r_divz_pend <= w_div_op && (b_i == '0);
         r_divz <= (r_state == FIX) && !flush_i && r_is_div && r_divz_pend;
      end
   end

   assign divz_o = r_divz;
`endif

   assign busy_o   = (r_state != IDLE);
   assign stall_o  = busy_o || w_md_start ||
                     (start_i && ((w_op == MD_MFHI) || (w_op == MD_MFLO)) && busy_o);
   assign done_o   = r_done;
   assign hi_o     = r_hi;
   assign lo_o     = r_lo;
   assign result_o = (w_op == MD_MFHI) ? r_hi : (w_op == MD_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: transaction-level model plus per-cycle compare.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        flush_i;
   logic        busy_o, stall_o, done_o;
   logic [31:0] hi_o, lo_o, result_o;
`ifdef MULDIV_DIVZ_FLAG_EN
   logic        divz_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;
   logic        exp_busy, exp_stall, exp_done, exp_divz;
   logic [31:0] exp_hi, exp_lo;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
      .hi_o(hi_o), .lo_o(lo_o), .result_o(result_o)
`ifdef MULDIV_DIVZ_FLAG_EN
      , .divz_o(divz_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result {HI,LO} computed with plain wide arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      case (op)
         3'd0: res = 64'(sa * sb);
         3'd1: res = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0) res = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Per-cycle compare against the expectation state held by the stimulus thread.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy_o",  64'(busy_o),  64'(exp_busy));
         chk("stall_o", 64'(stall_o), 64'(exp_stall));
         chk("done_o",  64'(done_o),  64'(exp_done));
         chk("hi_o",    64'(hi_o),    64'(exp_hi));
         chk("lo_o",    64'(lo_o),    64'(exp_lo));
         chk("result_o", 64'(result_o),
             64'((op_i == 3'd4) ? exp_hi : (op_i == 3'd5) ? exp_lo : 32'd0));
`ifdef MULDIV_DIVZ_FLAG_EN
         chk("divz_o",  64'(divz_o),  64'(exp_divz));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one mul/div op; optional flush in cycle flush_at, optional MF op held while busy.
   task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input int flush_at, input int mf);
      logic [63:0] r;
      r = model(o, aa, bb);
      start_i = 1'b1; op_i = o; a_i = aa; b_i = bb; flush_i = 1'b0;
      exp_busy = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_divz = 1'b0;
      step();
      for (int c = 1; c <= 33; c++) begin
         exp_busy = 1'b1; exp_stall = 1'b1;
         if (mf >= 0) begin
            start_i = 1'b1; op_i = 3'(mf);
         end else begin
            start_i = 1'($urandom_range(0, 1));
            op_i    = 3'($urandom_range(0, 7));
            a_i     = $urandom;
            b_i     = $urandom;
         end
         flush_i = (c == flush_at);
         step();
         if (c == flush_at) begin
            start_i = 1'b0; flush_i = 1'b0;
            exp_busy = 1'b0; exp_stall = 1'b0;
            step();
            return;
         end
      end
      start_i  = (mf >= 0);
      if (mf >= 0) op_i = 3'(mf);
      flush_i  = 1'b0;
      exp_busy = 1'b0; exp_stall = 1'b0; exp_done = 1'b1;
      exp_hi   = r[63:32];
      exp_lo   = r[31:0];
      exp_divz = ((o == 3'd2) || (o == 3'd3)) && (bb == 32'd0);
      step();
      start_i = 1'b0; exp_done = 1'b0; exp_divz = 1'b0;
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] v);
      start_i = 1'b1; op_i = o; a_i = v; flush_i = 1'b0;
      exp_busy = 1'b0; exp_stall = 1'b0;
      step();
      if (o == 3'd6) exp_hi = v; else exp_lo = v;
      start_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0; flush_i = 1'b0;
      exp_busy = 1'b0; exp_stall = 1'b0; exp_done = 1'b0; exp_divz = 1'b0;
      exp_hi = '0; exp_lo = '0;
      step();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;
      step();

      // Pin the model to hand-computed results.
      chk("pin_multu_max", model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("pin_mult_neg",  model(3'd0, 32'hFFFF_FFFD, 32'd7),         64'hFFFF_FFFF_FFFF_FFEB);
      chk("pin_div_neg",   model(3'd2, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
      chk("pin_divu",      model(3'd3, 32'd7, 32'd2),                 64'h0000_0001_0000_0003);
      chk("pin_divu_z",    model(3'd3, 32'h1234, 32'd0),              64'h0000_1234_FFFF_FFFF);
      chk("pin_div_ovf",   model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      chk("t1_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
      chk("t1_lo", 64'(lo_o), 64'h0000_0000_0000_0001);
      do_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, -1);
      chk("t2_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
      chk("t2_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFEB);
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
      chk("t3_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
      do_op(3'd3, 32'd7, 32'd2, -1, -1);
      chk("t3u_lo", 64'(lo_o), 64'd3);
      do_op(3'd3, 32'h1234, 32'd0, -1, -1);
      chk("t4_hi", 64'(hi_o), 64'h1234);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      chk("ovf_lo", 64'(lo_o), 64'h8000_0000);
      do_op(3'd0, 32'h0001_0000, 32'h0002_0000, 10, -1);
      chk("t5_hi_kept", 64'(hi_o), 64'h0);
      do_op(3'd3, 32'd100, 32'd7, -1, 5);
      chk("t6_lo", 64'(lo_o), 64'd14);
      mt(3'd6, 32'hA5A5_A5A5);
      chk("t6_mthi", 64'(hi_o), 64'hA5A5_A5A5);
      do_op(3'd1, 32'd5, 32'd6, 33, -1);

      // Flush and start in the same idle cycle: nothing starts.
      start_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd3; flush_i = 1'b1;
      exp_stall = 1'b1;
      step();
      start_i = 1'b0; flush_i = 1'b0; exp_stall = 1'b0;
      step();

      // Reset in the middle of an operation.
      start_i = 1'b1; op_i = 3'd1; a_i = 32'd9; b_i = 32'd9;
      exp_stall = 1'b1;
      step();
      start_i = 1'b0; exp_busy = 1'b1;
      repeat (4) step();
      rst_n = 1'b0;
      exp_busy = 1'b0; exp_stall = 1'b0; exp_hi = '0; exp_lo = '0;
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 60; i++) begin
         int k;
         k = int'($urandom_range(0, 9));
         if (k < 8)
            do_op(3'(k % 4), pick(), pick(),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : -1,
                  ($urandom_range(0, 3) == 0) ? int'(4 + $urandom_range(0, 1)) : -1);
         else
            mt(3'(k - 2), $urandom);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
